uart_tx_arbiter: RTL and testbench

Shares a single 8N1 serial transmit line between four byte-producing requesters on the clk_16MHz domain. A round-robin arbiter grants one requester per frame, latches its byte and frames it with start/stop bits at a fixed baud rate set by a divisor parameter. It sits between on-chip data sources (status, debug, sensor logic) and the PC-facing serial output pin, replacing per-source transmitters.

---
 rtl/uart_tx_arbiter.sv | 141 ++++++++++++++
 tb/tb_uart_tx_arbiter.sv | 276 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_arbiter.sv
// Four-requester round-robin arbiter feeding one 8N1 serial transmitter.
// One byte is granted per frame; all outputs come straight from flops.
module uart_tx_arbiter #(
  parameter int unsigned BAUD_DIV = 833
) (
  input  logic        clk_16MHz,
  input  logic        rst_n,
  input  logic [3:0]  req,
  input  logic [31:0] data_in,
  output logic [3:0]  ack,
  output logic [1:0]  grant_id,
  output logic        busy,
  output logic        ser_out
);

  typedef enum logic [1:0] {
    StIdle,
    StStart,
    StData,
    StStop
  } state_e;

  localparam logic [9:0] BitEnd = 10'(BAUD_DIV - 1);

  state_e      state_q, state_d;
  logic [9:0]  cnt_q, cnt_d;
  logic [2:0]  idx_q, idx_d;
  logic [7:0]  shreg_q, shreg_d;
  logic [3:0]  ack_q, ack_d;
  logic [1:0]  grant_q, grant_d;
  logic [1:0]  last_q, last_d;
  logic        busy_q, busy_d;
  logic        ser_q, ser_d;

  logic        bit_end;
  logic        win_valid;
  logic [1:0]  win_id;
  logic [1:0]  cand;

  assign bit_end = (cnt_q == BitEnd);

  // Search starts one past the last winner, so the previous winner gets lowest priority.
  always_comb begin
    win_valid = 1'b0;
    win_id    = '0;
    cand      = '0;
    for (int i = 1; i <= 4; i++) begin
      cand = last_q + 2'(i);
      if (!win_valid && req[cand]) begin
        win_valid = 1'b1;
        win_id    = cand;
      end
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = bit_end ? 10'd0 : cnt_q + 10'd1;
    idx_d   = idx_q;
    shreg_d = shreg_q;
    ack_d   = '0;
    grant_d = grant_q;
    last_d  = last_q;
    busy_d  = busy_q;
    ser_d   = ser_q;

    unique case (state_q)
      StIdle: begin
        cnt_d  = '0;
        ser_d  = 1'b1;
        busy_d = 1'b0;
        if (win_valid) begin
          shreg_d = data_in[{win_id, 3'b000} +: 8];
          ack_d   = 4'b0001 << win_id;
          grant_d = win_id;
          last_d  = win_id;
          ser_d   = 1'b0;
          busy_d  = 1'b1;
          state_d = StStart;
        end
      end
      StStart: begin
        if (bit_end) begin
          idx_d   = '0;
          ser_d   = shreg_q[0];
          state_d = StData;
        end
      end
      StData: begin
        if (bit_end) begin
          shreg_d = shreg_q >> 1;
          if (idx_q == 3'd7) begin
            ser_d   = 1'b1;
            state_d = StStop;
          end else begin
            idx_d = idx_q + 3'd1;
            ser_d = shreg_q[1];
          end
        end
      end
      StStop: begin
        if (bit_end) begin
          busy_d  = 1'b0;
          ser_d   = 1'b1;
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk_16MHz or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      idx_q   <= '0;
      shreg_q <= '0;
      ack_q   <= '0;
      grant_q <= '0;
      last_q  <= 2'd3;
      busy_q  <= 1'b0;
      ser_q   <= 1'b1;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      shreg_q <= shreg_d;
      ack_q   <= ack_d;
      grant_q <= grant_d;
      last_q  <= last_d;
      busy_q  <= busy_d;
      ser_q   <= ser_d;
    end
  end

  assign ack      = ack_q;
  assign grant_id = grant_q;
  assign busy     = busy_q;
  assign ser_out  = ser_q;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed bench for uart_tx_arbiter: a BAUD_DIV=4 instance for protocol
// scenarios and a default-divisor instance for full-rate bit timing.
module tb_uart_tx_arbiter;

  logic        clk_16MHz = 1'b0;
  logic        rst_n     = 1'b0;
  logic [3:0]  req       = '0;
  logic [31:0] data_in   = '0;
  logic [3:0]  ack;
  logic [1:0]  grant_id;
  logic        busy;
  logic        ser_out;

  logic [3:0]  req2  = '0;
  logic [31:0] data2 = '0;
  logic [3:0]  ack2;
  logic [1:0]  grant2;
  logic        busy2;
  logic        ser2;

  int errors = 0;
  int checks = 0;

  always #5 clk_16MHz = ~clk_16MHz;

  uart_tx_arbiter #(.BAUD_DIV(4)) u_dut (
    .clk_16MHz (clk_16MHz),
    .rst_n     (rst_n),
    .req       (req),
    .data_in   (data_in),
    .ack       (ack),
    .grant_id  (grant_id),
    .busy      (busy),
    .ser_out   (ser_out)
  );

  uart_tx_arbiter u_dut833 (
    .clk_16MHz (clk_16MHz),
    .rst_n     (rst_n),
    .req       (req2),
    .data_in   (data2),
    .ack       (ack2),
    .grant_id  (grant2),
    .busy      (busy2),
    .ser_out   (ser2)
  );

  task automatic do_reset();
    req = '0;
    @(negedge clk_16MHz);
    rst_n = 1'b0;
    repeat (2) @(negedge clk_16MHz);
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    @(negedge clk_16MHz);
    rst_n = 1'b0;
    #1;
    checks++; if (ser_out !== 1'b1) begin errors++; $display("FAIL reset_ser got %b want 1", ser_out); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b want 0", busy); end
    checks++; if (ack !== 4'b0000) begin errors++; $display("FAIL reset_ack got %b want 0000", ack); end
    checks++; if (grant_id !== 2'd0) begin errors++; $display("FAIL reset_grant got %0d want 0", grant_id); end
    @(negedge clk_16MHz);
    rst_n = 1'b1;
    repeat (3) @(negedge clk_16MHz);
    checks++; if (busy !== 1'b0 || ser_out !== 1'b1) begin
      errors++; $display("FAIL idle_no_req busy=%b ser=%b want 0/1", busy, ser_out);
    end
  endtask

  task automatic test_single();
    logic [9:0] fr;
    fr = {1'b1, 8'hA5, 1'b0};
    do_reset();
    req = 4'b0001;
    data_in = 32'h0000_00A5;
    @(negedge clk_16MHz);
    checks++; if (grant_id !== 2'd0) begin errors++; $display("FAIL single_grant got %0d want 0", grant_id); end
    req = '0;
    for (int k = 0; k < 40; k++) begin
      if (k > 0) @(negedge clk_16MHz);
      checks++; if (ser_out !== fr[k/4]) begin
        errors++; $display("FAIL single_ser k=%0d got %b want %b", k, ser_out, fr[k/4]);
      end
      checks++; if (busy !== 1'b1) begin errors++; $display("FAIL single_busy k=%0d got %b want 1", k, busy); end
      checks++; if (ack !== ((k == 0) ? 4'b0001 : 4'b0000)) begin
        errors++; $display("FAIL single_ack k=%0d got %b", k, ack);
      end
    end
    @(negedge clk_16MHz);
    checks++; if (busy !== 1'b0 || ser_out !== 1'b1) begin
      errors++; $display("FAIL single_end busy=%b ser=%b want 0/1", busy, ser_out);
    end
  endtask

  task automatic test_all_four();
    int exp_id [5] = '{0, 1, 2, 3, 0};
    logic [7:0] exp_byte [5] = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h11};
    logic [7:0] cur;
    logic [3:0] exp_ack;
    int n = 0;
    int t0 = 0;
    int off;
    cur = '0;
    do_reset();
    req = 4'b1111;
    data_in = 32'h4433_2211;
    for (int cyc = 0; cyc < 5 * 41 + 5 && n < 5; cyc++) begin
      @(negedge clk_16MHz);
      if (ack !== 4'b0000) begin
        exp_ack = 4'b0001 << exp_id[n];
        checks++; if (ack !== exp_ack) begin
          errors++; $display("FAIL four_ack n=%0d got %b want %b", n, ack, exp_ack);
        end
        checks++; if (grant_id !== 2'(exp_id[n])) begin
          errors++; $display("FAIL four_grant n=%0d got %0d want %0d", n, grant_id, exp_id[n]);
        end
        if (n > 0) begin
          checks++; if (cyc - t0 !== 41) begin
            errors++; $display("FAIL four_period n=%0d got %0d want 41", n, cyc - t0);
          end
        end
        cur = exp_byte[n];
        t0 = cyc;
        n++;
      end else if (n > 0) begin
        off = cyc - t0;
        if (off >= 4 && off < 36 && off % 4 == 0) begin
          checks++; if (ser_out !== cur[off/4-1]) begin
            errors++; $display("FAIL four_bit off=%0d got %b want %b", off, ser_out, cur[off/4-1]);
          end
        end
        if (off == 40) begin
          checks++; if (busy !== 1'b0 || ser_out !== 1'b1) begin
            errors++; $display("FAIL four_gap busy=%b ser=%b want 0/1", busy, ser_out);
          end
        end
      end
    end
    checks++; if (n !== 5) begin errors++; $display("FAIL four_count got %0d want 5", n); end
    req = '0;
  endtask

  task automatic test_fairness();
    int exp_id [4] = '{0, 3, 0, 3};
    logic [7:0] exp_byte [4] = '{8'h3C, 8'hC3, 8'h3C, 8'hC3};
    logic [7:0] cur;
    logic [3:0] exp_ack;
    int n = 0;
    int t0 = 0;
    int off;
    cur = '0;
    do_reset();
    req = 4'b1001;
    data_in = 32'hC300_003C;
    for (int cyc = 0; cyc < 4 * 41 + 5 && n < 4; cyc++) begin
      @(negedge clk_16MHz);
      if (ack !== 4'b0000) begin
        exp_ack = 4'b0001 << exp_id[n];
        checks++; if (ack !== exp_ack) begin
          errors++; $display("FAIL fair_ack n=%0d got %b want %b", n, ack, exp_ack);
        end
        if (n > 0) begin
          checks++; if (cyc - t0 !== 41) begin
            errors++; $display("FAIL fair_period n=%0d got %0d want 41", n, cyc - t0);
          end
        end
        cur = exp_byte[n];
        t0 = cyc;
        n++;
      end else if (n > 0) begin
        off = cyc - t0;
        if (off >= 4 && off < 36 && off % 4 == 0) begin
          checks++; if (ser_out !== cur[off/4-1]) begin
            errors++; $display("FAIL fair_bit off=%0d got %b want %b", off, ser_out, cur[off/4-1]);
          end
        end
      end
    end
    checks++; if (n !== 4) begin errors++; $display("FAIL fair_count got %0d want 4", n); end
    req = '0;
  endtask

  task automatic test_withdrawn();
    do_reset();
    req = 4'b0001;
    data_in = 32'h0000_00A5;
    @(negedge clk_16MHz);
    checks++; if (ack !== 4'b0001) begin errors++; $display("FAIL wd_first_ack got %b want 0001", ack); end
    req = '0;
    repeat (10) @(negedge clk_16MHz);
    req = 4'b0100;
    @(negedge clk_16MHz);
    req = '0;
    for (int k = 0; k < 80; k++) begin
      @(negedge clk_16MHz);
      checks++; if (ack !== 4'b0000) begin errors++; $display("FAIL wd_ack k=%0d got %b want 0000", k, ack); end
    end
    checks++; if (busy !== 1'b0 || ser_out !== 1'b1) begin
      errors++; $display("FAIL wd_idle busy=%b ser=%b want 0/1", busy, ser_out);
    end
  endtask

  task automatic test_reset_mid();
    logic [9:0] fr;
    fr = {1'b1, 8'h5A, 1'b0};
    do_reset();
    req = 4'b0001;
    data_in = 32'h005A_00A5;
    @(negedge clk_16MHz);
    checks++; if (ack !== 4'b0001) begin errors++; $display("FAIL mid_first_ack got %b want 0001", ack); end
    req = '0;
    repeat (17) @(negedge clk_16MHz);
    // Data bit 3 of 8'hA5 is 0, so the line is low just before reset.
    checks++; if (ser_out !== 1'b0) begin errors++; $display("FAIL mid_bit3 got %b want 0", ser_out); end
    rst_n = 1'b0;
    #1;
    checks++; if (ser_out !== 1'b1) begin errors++; $display("FAIL mid_rst_ser got %b want 1", ser_out); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL mid_rst_busy got %b want 0", busy); end
    checks++; if (ack !== 4'b0000) begin errors++; $display("FAIL mid_rst_ack got %b want 0000", ack); end
    @(negedge clk_16MHz);
    rst_n = 1'b1;
    req = 4'b0100;
    @(negedge clk_16MHz);
    checks++; if (ack !== 4'b0100) begin errors++; $display("FAIL mid_ack2 got %b want 0100", ack); end
    checks++; if (grant_id !== 2'd2) begin errors++; $display("FAIL mid_grant got %0d want 2", grant_id); end
    req = '0;
    for (int k = 0; k < 40; k++) begin
      if (k > 0) @(negedge clk_16MHz);
      checks++; if (ser_out !== fr[k/4] || busy !== 1'b1) begin
        errors++; $display("FAIL mid_frame k=%0d ser=%b busy=%b want %b/1", k, ser_out, busy, fr[k/4]);
      end
    end
    @(negedge clk_16MHz);
    checks++; if (busy !== 1'b0 || ser_out !== 1'b1) begin
      errors++; $display("FAIL mid_end busy=%b ser=%b want 0/1", busy, ser_out);
    end
  endtask

  task automatic test_default_baud();
    logic [9:0] fr;
    fr = {1'b1, 8'h55, 1'b0};
    @(negedge clk_16MHz);
    req2 = 4'b0001;
    data2 = 32'h0000_0055;
    @(negedge clk_16MHz);
    checks++; if (ack2 !== 4'b0001 || grant2 !== 2'd0) begin
      errors++; $display("FAIL def_ack got %b/%0d want 0001/0", ack2, grant2);
    end
    req2 = '0;
    for (int k = 0; k < 8330; k++) begin
      if (k > 0) @(negedge clk_16MHz);
      checks++; if (ser2 !== fr[k/833] || busy2 !== 1'b1) begin
        errors++; $display("FAIL def_frame k=%0d ser=%b busy=%b want %b/1", k, ser2, busy2, fr[k/833]);
      end
    end
    @(negedge clk_16MHz);
    checks++; if (busy2 !== 1'b0 || ser2 !== 1'b1) begin
      errors++; $display("FAIL def_end busy=%b ser=%b want 0/1", busy2, ser2);
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_all_four();
    test_fairness();
    test_withdrawn();
    test_reset_mid();
    test_default_baud();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
